// File: rtl/ppu_pkg.sv
// Definitions shared by the data RAM, the control unit and the RAM port arbiter:
// arbiter state encoding and access-size codes.
package ppu_pkg;

  typedef enum logic {
    ARB_P_OWN   = 1'b0,
    ARB_X_FORCE = 1'b1
  } arb_state_t;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10
  } mem_size_t;

endpackage

// File: rtl/dram_req_mux.sv
// Two-way payload mux steering either the pipeline or the external request onto
// the data RAM control lines. Purely combinational.
module dram_req_mux #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input  logic              sel_x,
  input  logic              p_e,
  input  logic              p_rw,
  input  logic [1:0]        p_size,
  input  logic              p_se,
  input  logic [ADDR_W-1:0] p_addr,
  input  logic [DATA_W-1:0] p_wdata,
  input  logic              x_e,
  input  logic              x_rw,
  input  logic [1:0]        x_size,
  input  logic              x_se,
  input  logic [ADDR_W-1:0] x_addr,
  input  logic [DATA_W-1:0] x_wdata,
  output logic [ADDR_W-1:0] ram_a,
  output logic [DATA_W-1:0] ram_di,
  output logic [1:0]        ram_size,
  output logic              ram_rw,
  output logic              ram_e,
  output logic              ram_se
);

  assign ram_e    = sel_x ? x_e     : p_e;
  assign ram_rw   = sel_x ? x_rw    : p_rw;
  assign ram_size = sel_x ? x_size  : p_size;
  assign ram_se   = sel_x ? x_se    : p_se;
  assign ram_a    = sel_x ? x_addr  : p_addr;
  assign ram_di   = sel_x ? x_wdata : p_wdata;

endmodule

// File: rtl/dram_port_arbiter.sv
// Shares the single-port data RAM between the pipeline MEM stage (priority) and an
// external loader/debug port, forcing one external slot after STARVE_LIMIT blocked cycles.
module dram_port_arbiter
  import ppu_pkg::*;
#(
  parameter int ADDR_W       = 9,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p_e,
  input  logic              p_rw,
  input  logic [1:0]        p_size,
  input  logic              p_se,
  input  logic [ADDR_W-1:0] p_addr,
  input  logic [DATA_W-1:0] p_wdata,
  output logic [DATA_W-1:0] p_rdata,
  output logic              p_stall,
  input  logic              x_valid,
  output logic              x_ready,
  input  logic              x_rw,
  input  logic [1:0]        x_size,
  input  logic              x_se,
  input  logic [ADDR_W-1:0] x_addr,
  input  logic [DATA_W-1:0] x_wdata,
  output logic [DATA_W-1:0] x_rdata,
  output logic              x_rvalid,
  output logic [ADDR_W-1:0] ram_a,
  output logic [DATA_W-1:0] ram_di,
  output logic [1:0]        ram_size,
  output logic              ram_rw,
  output logic              ram_e,
  output logic              ram_se,
  input  logic [DATA_W-1:0] ram_do
);

  localparam int              CNT_W    = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STARVE_LIMIT - 1);

  arb_state_t       state, state_next;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_next;
  logic             contested;
  logic             x_own;

  assign contested = x_valid && p_e;

  // Reset drops any grant combinationally so the RAM reverts to the pipeline at once.
  always_comb begin
    x_own = 1'b0;
    if (!reset) x_own = (state == ARB_X_FORCE) ? x_valid : (x_valid && !p_e);
  end

  assign x_ready = x_own;
  assign p_stall = !reset && (state == ARB_X_FORCE) && contested;
  assign p_rdata = ram_do;

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    state_next    = ARB_P_OWN;
    wait_cnt_next = '0;
    if (state == ARB_P_OWN && contested) begin
      if (wait_cnt == CNT_LAST) state_next    = ARB_X_FORCE;
      else                      wait_cnt_next = wait_cnt + CNT_W'(1);
    end
  end

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ARB_P_OWN;
      wait_cnt <= '0;
      x_rdata  <= '0;
      x_rvalid <= 1'b0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
      x_rvalid <= x_own && !x_rw;
      if (x_own && !x_rw) x_rdata <= ram_do;
    end
  end

  dram_req_mux #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mux (
    .sel_x    (x_own),
    .p_e      (p_e),
    .p_rw     (p_rw),
    .p_size   (p_size),
    .p_se     (p_se),
    .p_addr   (p_addr),
    .p_wdata  (p_wdata),
    .x_e      (x_valid),
    .x_rw     (x_rw),
    .x_size   (x_size),
    .x_se     (x_se),
    .x_addr   (x_addr),
    .x_wdata  (x_wdata),
    .ram_a    (ram_a),
    .ram_di   (ram_di),
    .ram_size (ram_size),
    .ram_rw   (ram_rw),
    .ram_e    (ram_e),
    .ram_se   (ram_se)
  );

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Bench for dram_port_arbiter: directed corner cases, then randomized traffic checked
// against a memory/grant reference model with a scoreboard for external read data.
module tb_dram_port_arbiter;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 32;
  localparam int LIMIT  = 4;
  localparam logic [ADDR_W-1:0] RBASE = 9'h100;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              p_e = 1'b0, p_rw = 1'b0, p_se = 1'b0;
  logic [1:0]        p_size = 2'b10;
  logic [ADDR_W-1:0] p_addr = '0;
  logic [DATA_W-1:0] p_wdata = '0;
  logic              x_valid = 1'b0, x_rw = 1'b0, x_se = 1'b0;
  logic [1:0]        x_size = 2'b10;
  logic [ADDR_W-1:0] x_addr = '0;
  logic [DATA_W-1:0] x_wdata = '0;
  logic [DATA_W-1:0] p_rdata, x_rdata, ram_di, ram_do;
  logic              p_stall, x_ready, x_rvalid, ram_rw, ram_e, ram_se;
  logic [ADDR_W-1:0] ram_a;
  logic [1:0]        ram_size;

  dram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .p_e(p_e), .p_rw(p_rw), .p_size(p_size), .p_se(p_se), .p_addr(p_addr), .p_wdata(p_wdata),
    .p_rdata(p_rdata), .p_stall(p_stall),
    .x_valid(x_valid), .x_ready(x_ready), .x_rw(x_rw), .x_size(x_size), .x_se(x_se),
    .x_addr(x_addr), .x_wdata(x_wdata), .x_rdata(x_rdata), .x_rvalid(x_rvalid),
    .ram_a(ram_a), .ram_di(ram_di), .ram_size(ram_size), .ram_rw(ram_rw), .ram_e(ram_e),
    .ram_se(ram_se), .ram_do(ram_do)
  );

  always #5 clk = ~clk;

  // Word-wide RAM behind the arbiter: combinational read, write on the clock edge.
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1] = '{default: '0};
  assign ram_do = mem[ram_a];
  always @(posedge clk) if (ram_e && ram_rw) mem[ram_a] <= ram_di;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [DATA_W-1:0] data;
    int                due;
  } exp_t;
  exp_t exp_q[$];

  // Monitor: every x_rvalid pulse must match the oldest expected read, on its due cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!reset) begin
        if (x_rvalid) begin
          if (exp_q.size() == 0) check("x_rvalid_unexpected", 64'(x_rvalid), 64'd0);
          else begin
            e = exp_q.pop_front();
            check("x_rdata", 64'(x_rdata), 64'(e.data));
            check("x_rvalid_cycle", 64'(cyc), 64'(e.due));
          end
        end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
          e = exp_q.pop_front();
          check("x_rvalid_missing", 64'(x_rvalid), 64'd1);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive_p(input logic e, input logic rw, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d);
    p_e = e; p_rw = rw; p_addr = a; p_wdata = d; p_size = 2'b10; p_se = 1'b0;
  endtask

  task automatic drive_x(input logic v, input logic rw, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d);
    x_valid = v; x_rw = rw; x_addr = a; x_wdata = d; x_size = 2'b10; x_se = 1'b0;
  endtask

  // Called just after driving at a falling edge; returns the 1-based cycle of the grant (0 = none).
  task automatic run_until_grant(input int max, output int n);
    n = 0;
    for (int k = 1; k <= max; k++) begin
      #1;
      if (x_ready) begin
        n = k;
        break;
      end
      @(negedge clk);
    end
  endtask

  logic [DATA_W-1:0] ref_mem [0:31] = '{default: '0};

  initial begin
    int n;
    int c0;
    int run;
    int waited;
    bit pend;
    bit prev_stall;
    bit exp_grant, exp_stall;
    logic [44:0] exp_pay;

    // Reset state, with an external request already pending and the pipeline idle.
    drive_p(1'b0, 1'b0, 9'h033, 32'h0);
    drive_x(1'b1, 1'b0, 9'h055, 32'h0);
    #12;
    check("rst_x_ready", 64'(x_ready), 64'd0);
    check("rst_p_stall", 64'(p_stall), 64'd0);
    check("rst_ram_e", 64'(ram_e), 64'd0);
    check("rst_ram_a", 64'(ram_a), 64'h033);
    check("rst_x_rvalid", 64'(x_rvalid), 64'd0);
    check("rst_x_rdata", 64'(x_rdata), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    drive_x(1'b0, 1'b0, 9'h0, 32'h0);

    // Preload through the pipeline port: zero-latency store.
    @(negedge clk);
    drive_p(1'b1, 1'b1, 9'h010, 32'hDEADBEEF);
    #1;
    check("p_store_ram_a", 64'({ram_e, ram_rw, ram_a, ram_di}), 64'({2'b11, 9'h010, 32'hDEADBEEF}));

    // Idle pipeline: external read granted at once, data one cycle later.
    @(negedge clk);
    drive_p(1'b0, 1'b0, 9'h000, 32'h0);
    drive_x(1'b1, 1'b0, 9'h010, 32'h0);
    exp_q.push_back('{data: 32'hDEADBEEF, due: cyc + 1});
    #1;
    check("t1_x_ready", 64'(x_ready), 64'd1);
    check("t1_p_stall", 64'(p_stall), 64'd0);
    check("t1_ram", 64'({ram_e, ram_rw, ram_a}), 64'({2'b10, 9'h010}));
    check("t1_p_rdata", 64'(p_rdata), 64'hDEADBEEF);
    @(negedge clk);
    drive_x(1'b0, 1'b0, 9'h0, 32'h0);
    #1;
    check("t1_idle_p_stall", 64'(p_stall), 64'd0);

    // Busy pipeline: external write forced in cycle LIMIT+1 with a one-cycle stall.
    @(negedge clk);
    drive_p(1'b1, 1'b0, 9'h011, 32'h0);
    drive_x(1'b1, 1'b1, 9'h020, 32'h12345678);
    for (int k = 1; k <= LIMIT + 1; k++) begin
      #1;
      if (k <= LIMIT) begin
        check("t2_wait_x_ready", 64'(x_ready), 64'd0);
        check("t2_wait_p_stall", 64'(p_stall), 64'd0);
      end else begin
        check("t2_force_x_ready", 64'(x_ready), 64'd1);
        check("t2_force_p_stall", 64'(p_stall), 64'd1);
        check("t2_force_ram", 64'({ram_rw, ram_a, ram_di}), 64'({1'b1, 9'h020, 32'h12345678}));
      end
      @(negedge clk);
    end
    drive_x(1'b0, 1'b0, 9'h0, 32'h0);
    #1;
    check("t2_after_p_owns", 64'({p_stall, ram_rw, ram_a}), 64'({2'b00, 9'h011}));
    check("t2_written", 64'(mem[9'h020]), 64'h12345678);

    // Simultaneous first request: pipeline store wins, forced external read sees it.
    @(negedge clk);
    drive_p(1'b1, 1'b1, 9'h004, 32'hAAAA5555);
    drive_x(1'b1, 1'b0, 9'h004, 32'h0);
    exp_q.push_back('{data: 32'hAAAA5555, due: cyc + LIMIT + 1});
    #1;
    check("t3_first_p_wins", 64'({x_ready, ram_rw, ram_a}), 64'({2'b01, 9'h004}));
    run_until_grant(LIMIT + 3, n);
    check("t3_grant_latency", 64'(n), 64'(LIMIT + 1));
    @(negedge clk);
    drive_x(1'b0, 1'b0, 9'h0, 32'h0);
    drive_p(1'b0, 1'b0, 9'h0, 32'h0);

    // Request withdrawn in the forced slot: no stall, no write, counter restarts.
    @(negedge clk);
    drive_p(1'b1, 1'b0, 9'h042, 32'h0);
    drive_x(1'b1, 1'b1, 9'h040, 32'h0BADF00D);
    for (int k = 1; k <= LIMIT; k++) begin
      #1;
      check("t4_wait_x_ready", 64'(x_ready), 64'd0);
      @(negedge clk);
    end
    drive_x(1'b0, 1'b1, 9'h040, 32'h0BADF00D);
    #1;
    check("t4_drop_p_stall", 64'(p_stall), 64'd0);
    check("t4_drop_ram", 64'({ram_e, ram_rw, ram_a}), 64'({2'b10, 9'h042}));
    @(negedge clk);
    check("t4_no_write", 64'(mem[9'h040]), 64'd0);
    drive_x(1'b1, 1'b1, 9'h041, 32'h00005A5A);
    run_until_grant(LIMIT + 3, n);
    check("t4_regrant_latency", 64'(n), 64'(LIMIT + 1));
    @(negedge clk);
    drive_x(1'b0, 1'b0, 9'h0, 32'h0);

    // Reset pulsed during the forced slot: grant aborted, request served afresh later.
    drive_x(1'b1, 1'b0, 9'h010, 32'h0);
    for (int k = 1; k <= LIMIT; k++) @(negedge clk);
    #1;
    check("t5_in_force_p_stall", 64'(p_stall), 64'd1);
    reset = 1'b1;
    #1;
    check("t5_rst_x_ready", 64'(x_ready), 64'd0);
    check("t5_rst_p_stall", 64'(p_stall), 64'd0);
    check("t5_rst_ram_a", 64'(ram_a), 64'h042);
    check("t5_rst_x_rvalid", 64'(x_rvalid), 64'd0);
    check("t5_rst_x_rdata", 64'(x_rdata), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    exp_q.push_back('{data: 32'hDEADBEEF, due: cyc + LIMIT + 1});
    run_until_grant(LIMIT + 3, n);
    check("t5_regrant_latency", 64'(n), 64'(LIMIT + 1));
    @(negedge clk);
    drive_x(1'b0, 1'b0, 9'h0, 32'h0);
    drive_p(1'b0, 1'b0, 9'h0, 32'h0);
    @(negedge clk);

    // Randomized traffic in a private address window against the reference model.
    run = 0;
    pend = 1'b0;
    prev_stall = 1'b0;
    waited = 0;
    for (int t = 0; t < 2000; t++) begin
      @(negedge clk);
      if (!prev_stall) begin
        p_e     = ($urandom_range(0, 3) != 0);
        p_rw    = 1'($urandom_range(0, 1));
        p_addr  = RBASE + 9'($urandom_range(0, 31));
        p_wdata = $urandom;
        p_size  = 2'($urandom_range(0, 2));
        p_se    = 1'($urandom_range(0, 1));
      end
      if (!pend) x_valid = 1'b0;
      if (!pend && $urandom_range(0, 2) == 0) begin
        pend    = 1'b1;
        waited  = 0;
        x_valid = 1'b1;
        x_rw    = 1'($urandom_range(0, 1));
        x_addr  = RBASE + 9'($urandom_range(0, 31));
        x_wdata = $urandom;
        x_size  = 2'($urandom_range(0, 2));
        x_se    = 1'($urandom_range(0, 1));
      end
      if (pend) waited++;

      // External port wins when the pipeline is idle or after LIMIT consecutive losses.
      exp_grant = x_valid && (!p_e || run == LIMIT);
      exp_stall = exp_grant && p_e;
      exp_pay = exp_grant ? {x_addr, x_wdata, x_size, x_rw, x_se}
                          : {p_addr, p_wdata, p_size, p_rw, p_se};
      #1;
      check("r_x_ready", 64'(x_ready), 64'(exp_grant));
      check("r_p_stall", 64'(p_stall), 64'(exp_stall));
      check("r_ram_e", 64'(ram_e), 64'(p_e || x_valid));
      check("r_ram_payload", 64'({ram_a, ram_di, ram_size, ram_rw, ram_se}), 64'(exp_pay));
      if (p_e && !p_rw && !exp_stall)
        check("r_p_rdata", 64'(p_rdata), 64'(ref_mem[p_addr[4:0]]));
      if (p_stall && prev_stall) check("r_p_stall_consecutive", 64'(p_stall), 64'd0);
      if (pend && !x_ready && waited >= LIMIT + 1) check("r_x_grant_timeout", 64'(x_ready), 64'd1);

      if (exp_grant && !x_rw) exp_q.push_back('{data: ref_mem[x_addr[4:0]], due: cyc + 1});
      if (exp_grant) begin
        if (x_rw) ref_mem[x_addr[4:0]] = x_wdata;
      end else if (p_e && p_rw) begin
        ref_mem[p_addr[4:0]] = p_wdata;
      end
      if (exp_grant)              run = 0;
      else if (x_valid && p_e)    run++;
      else                        run = 0;

      if (x_ready) pend = 1'b0;
      prev_stall = p_stall;
    end

    @(negedge clk);
    drive_x(1'b0, 1'b0, 9'h0, 32'h0);
    drive_p(1'b0, 1'b0, 9'h0, 32'h0);
    repeat (3) @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
